uart_tx_fifo: RTL and testbench

- 8N1 UART transmitter; the send-side counterpart of the board's 9600-baud keyboard receive path.
- Accepts bytes from game or debug logic through a valid/ready handshake into a small FIFO.
- Serialises bytes LSB-first onto the data_t line.
- Baud timing is generated internally from the system clock; no external baud clock is used.

---
 rtl/uart_tx_fifo.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO through a valid/ready handshake.
// Baud timing is derived internally from clk; the serial line idles high.
module uart_tx_fifo #(
    parameter int BAUD_DIV   = 10417,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          data_t,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          r_state;
    logic            r_data_t;
    logic [BW-1:0]   r_baud_cnt;
    logic [2:0]      r_bit_cnt;
    logic            r_stop_cnt;
    logic [7:0]      r_shift;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_tx_ready;
    logic            r_not_empty;

    state_t          w_state_next;
    logic            w_data_t_next;
    logic [BW-1:0]   w_baud_next;
    logic [2:0]      w_bit_next;
    logic            w_stop_next;
    logic [7:0]      w_shift_next;
    logic            w_pop;
    logic            w_push;
    logic            w_baud_last;
    logic [CW-1:0]   w_count_next;

    assign w_push      = tx_valid && r_tx_ready;
    assign w_baud_last = (r_baud_cnt == BAUD_LAST);

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // The FSM looks at a one-cycle-late copy of "non-empty" so a freshly
    // pushed byte is never popped on the edge right after it was written.
    always_comb begin
        w_state_next  = r_state;
        w_data_t_next = r_data_t;
        w_baud_next   = r_baud_cnt;
        w_bit_next    = r_bit_cnt;
        w_stop_next   = r_stop_cnt;
        w_shift_next  = r_shift;
        w_pop         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_data_t_next = 1'b1;
                if (r_not_empty) begin
                    w_pop         = 1'b1;
                    w_shift_next  = r_mem[r_rd_ptr];
                    w_data_t_next = 1'b0;
                    w_baud_next   = '0;
                    w_state_next  = S_START;
                end
            end
            S_START: begin
                if (w_baud_last) begin
                    w_data_t_next = r_shift[0];
                    w_bit_next    = '0;
                    w_baud_next   = '0;
                    w_state_next  = S_DATA;
                end else begin
                    w_baud_next = r_baud_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_baud_last) begin
                    w_baud_next = '0;
                    if (r_bit_cnt == 3'd7) begin
                        w_data_t_next = 1'b1;
                        w_stop_next   = 1'b0;
                        w_state_next  = S_STOP;
                    end else begin
                        w_shift_next  = {1'b0, r_shift[7:1]};
                        w_data_t_next = r_shift[1];
                        w_bit_next    = r_bit_cnt + 1'b1;
                    end
                end else begin
                    w_baud_next = r_baud_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (w_baud_last) begin
                    w_baud_next = '0;
                    if (r_stop_cnt == STOP_LAST) begin
                        // Chain straight into the next start bit when more data waits.
                        if (r_not_empty) begin
                            w_pop         = 1'b1;
                            w_shift_next  = r_mem[r_rd_ptr];
                            w_data_t_next = 1'b0;
                            w_state_next  = S_START;
                        end else begin
                            w_state_next  = S_IDLE;
                        end
                    end else begin
                        w_stop_next = r_stop_cnt + 1'b1;
                    end
                end else begin
                    w_baud_next = r_baud_cnt + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_data_t    <= 1'b1;
            r_baud_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_stop_cnt  <= 1'b0;
            r_shift     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_tx_ready  <= 1'b0;
            r_not_empty <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_data_t    <= w_data_t_next;
            r_baud_cnt  <= w_baud_next;
            r_bit_cnt   <= w_bit_next;
            r_stop_cnt  <= w_stop_next;
            r_shift     <= w_shift_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count     <= w_count_next;
            r_tx_ready  <= (w_count_next != DEPTH_CNT);
            r_not_empty <= (r_count != '0);
        end
    end

    assign tx_ready   = r_tx_ready;
    assign data_t     = r_data_t;
    assign fifo_count = r_count;
    assign busy       = (r_state != S_IDLE) || (r_count != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a line monitor decodes frames from two
// instances (1 and 2 stop bits) and the main sequence checks them against constants.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int BD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data1, tx_data2;
    logic       tx_valid1, tx_valid2;
    logic       tx_ready1, tx_ready2;
    logic       data_t1, data_t2;
    logic       busy1, busy2;
    logic [2:0] fifo_count1, fifo_count2;

    always #5 clk = ~clk;

    uart_tx_fifo #(.BAUD_DIV(BD), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready1), .data_t(data_t1), .busy(busy1), .fifo_count(fifo_count1)
    );

    uart_tx_fifo #(.BAUD_DIV(BD), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .data_t(data_t2), .busy(busy2), .fifo_count(fifo_count2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: got=%0h", tag, got);
        end
    endtask

    typedef struct {
        int         inst;
        logic [7:0] data;
        int         start;
        bit         ok;
        logic       busy_end;
    } frame_t;

    frame_t rxq[$];

    function automatic frame_t decode(input int inst, input logic [43:0] s, input int nstop,
                                      input int st, input logic bz);
        frame_t r;
        r.inst = inst; r.start = st; r.busy_end = bz; r.ok = 1'b1; r.data = '0;
        for (int j = 0; j < 9 + nstop; j++) begin
            for (int c = 1; c < BD; c++) if (s[j*BD + c] !== s[j*BD]) r.ok = 1'b0;
            if (j == 0 && s[0] !== 1'b0) r.ok = 1'b0;
            if (j >= 9 && s[j*BD] !== 1'b1) r.ok = 1'b0;
        end
        for (int b = 0; b < 8; b++) r.data[b] = s[(b+1)*BD];
        return r;
    endfunction

    // Every cycle of a frame is sampled so both level and exact bit length are captured.
    int          m_idx   [2] = '{0, 0};
    int          m_start [2];
    logic [43:0] m_smp   [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic ln;
            logic bz;
            int   len;
            ln  = (i == 0) ? data_t1 : data_t2;
            bz  = (i == 0) ? busy1 : busy2;
            len = (i == 0) ? 10 * BD : 11 * BD;
            if (!rst_n) begin
                m_idx[i] = 0;
            end else if (m_idx[i] == 0) begin
                if (ln === 1'b0) begin
                    m_smp[i]   = '0;
                    m_start[i] = cyc;
                    m_idx[i]   = 1;
                end
            end else begin
                m_smp[i][m_idx[i]] = ln;
                m_idx[i]++;
                if (m_idx[i] == len) begin
                    rxq.push_back(decode(i, m_smp[i], (i == 0) ? 1 : 2, m_start[i], bz));
                    m_idx[i] = 0;
                end
            end
        end
    end

    task automatic push1(input int inst, input logic [7:0] d, output int pc);
        int k;
        k = 0;
        @(negedge clk);
        while (((inst == 0) ? tx_ready1 : tx_ready2) !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (inst == 0) begin tx_data1 = d; tx_valid1 = 1'b1; end
        else           begin tx_data2 = d; tx_valid2 = 1'b1; end
        @(negedge clk);
        pc = cyc;
        tx_valid1 = 1'b0;
        tx_valid2 = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (rxq.size() < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_val("frames_arrived", rxq.size(), n);
    endtask

    logic [7:0] bb [5];
    int         bstart [5];
    int         p0, p1, p2, pr, pq, pz, t_edge, base;
    frame_t     f;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bb = '{8'h00, 8'hFF, 8'h55, 8'h3C, 8'h81};
        rst_n = 1'b0;
        tx_valid1 = 1'b0; tx_valid2 = 1'b0;
        tx_data1 = 8'h00; tx_data2 = 8'h00;

        // Reset sanity
        repeat (5) @(negedge clk);
        check_val("rst_data_t", data_t1, 1);
        check_val("rst_data_t2", data_t2, 1);
        check_val("rst_tx_ready", tx_ready1, 0);
        check_val("rst_busy", busy1, 0);
        check_val("rst_fifo_count", fifo_count1, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("ready_after_rst", tx_ready1, 1);

        // Single byte 0xA5
        push1(0, 8'hA5, p0);
        check_val("a5_busy_after_push", busy1, 1);
        wait_frames(1, 100);
        if (rxq.size() >= 1) begin
            f = rxq.pop_front();
            check_val("a5_data", f.data, 8'hA5);
            check_val("a5_framing", f.ok, 1);
            check_val("a5_latency", f.start - p0, 2);
            check_val("a5_busy_last_cycle", f.busy_end, 1);
            check_val("a5_busy_after", busy1, 0);
        end

        // Burst of five on consecutive cycles
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            tx_data1 = bb[i];
            tx_valid1 = 1'b1;
            check_val("burst_ready", tx_ready1, 1);
            @(negedge clk);
            if (i == 0) p0 = cyc;
        end
        tx_data1 = 8'hEE;
        check_val("burst_full_count", fifo_count1, 4);
        check_val("burst_full_ready", tx_ready1, 0);
        repeat (3) @(negedge clk);
        check_val("burst_no_push_when_full", fifo_count1, 4);
        tx_valid1 = 1'b0;
        tx_data1 = 8'h11;
        wait_frames(5, 5 * 10 * BD + 60);
        for (int i = 0; i < 5; i++) begin
            if (rxq.size() >= 1) begin
                f = rxq.pop_front();
                bstart[i] = f.start;
                check_val("burst_data", f.data, bb[i]);
                check_val("burst_framing", f.ok, 1);
                if (i == 0) check_val("burst_latency", f.start - p0, 2);
                else        check_val("burst_contiguous", f.start - bstart[i-1], 10 * BD);
            end
        end
        check_val("burst_busy_after", busy1, 0);

        // Simultaneous push and pop with one entry stored
        push1(0, 8'h12, p1);
        push1(0, 8'h34, p2);
        t_edge = p1 + 2 + 10 * BD;
        while (cyc < t_edge - 1) @(negedge clk);
        check_val("pp_count_before", fifo_count1, 1);
        tx_data1 = 8'h56;
        tx_valid1 = 1'b1;
        @(negedge clk);
        tx_valid1 = 1'b0;
        tx_data1 = 8'hC3;
        check_val("pp_count_after", fifo_count1, 1);
        wait_frames(3, 3 * 10 * BD + 60);
        base = p1 + 2;
        for (int i = 0; i < 3; i++) begin
            if (rxq.size() >= 1) begin
                f = rxq.pop_front();
                check_val("pp_data", f.data, (i == 0) ? 8'h12 : (i == 1) ? 8'h34 : 8'h56);
                check_val("pp_framing", f.ok, 1);
                check_val("pp_start", f.start - base, i * 10 * BD);
            end
        end

        // Reset in the middle of 0x0F with 0x99 still queued
        push1(0, 8'h0F, pr);
        push1(0, 8'h99, pq);
        while (cyc < pr + 2 + 5 * BD + 1) @(negedge clk);
        check_val("mid_line_low_before_rst", data_t1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_line_high", data_t1, 1);
        check_val("mid_rst_count", fifo_count1, 0);
        check_val("mid_rst_busy", busy1, 0);
        check_val("mid_rst_ready", tx_ready1, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check_val("mid_no_residual_frame", rxq.size(), 0);
        check_val("mid_line_idle", data_t1, 1);
        check_val("mid_busy_idle", busy1, 0);

        // Two-stop-bit instance, byte 0x7E
        push1(1, 8'h7E, pz);
        wait_frames(1, 120);
        if (rxq.size() >= 1) begin
            f = rxq.pop_front();
            check_val("stop2_inst", f.inst, 1);
            check_val("stop2_data", f.data, 8'h7E);
            check_val("stop2_framing", f.ok, 1);
            check_val("stop2_latency", f.start - pz, 2);
            check_val("stop2_busy_last_cycle", f.busy_end, 1);
            check_val("stop2_busy_after", busy2, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
